// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage feeding the IF/ID pipeline register.
// Holds the PC and keeps at most one imem read outstanding over a
// req/gnt/rvalid handshake. Each fetched word is presented on IF_inst/IF_pc
// for exactly one cycle. IF_inst is NOP_INST and IF_pc is 0 in every other cycle.
// Stalls hold the fetched word in a one-entry buffer and replay it later.
// A redirect discards any work still in flight.
// Optional build macro: FETCH_BYPASS_EN. When it is defined, a response that
// arrives with no stall is delivered in the same cycle and does not pass
// through HOLD.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_FETCH | request imem at r_pc_reg and wait for the grant
// S_WAIT  | request granted, waiting for rvalid (r_discard drops it)
// S_HOLD  | response buffered, deliver once the stall and redirect are low
module if_fetch #(
    parameter logic [0:31] RESET_PC = 32'h0000_0000,
    parameter logic [0:31] NOP_INST = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IF_stall,
    input  logic        br_taken,
    input  logic [0:31] br_target,
    output logic        imem_req,
    output logic [0:31] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [0:31] imem_rdata,
    output logic [0:31] IF_inst,
    output logic [0:31] IF_pc
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    logic [0:31] r_pc_reg;
    logic [0:31] r_req_pc;
    logic [0:31] r_buf_inst;
    logic [0:31] r_buf_pc;
    logic        r_buf_valid;
    logic        r_discard;

    logic        w_req;
    logic        w_hold_deliver;
    logic        w_bypass;

    // A request is issued only in FETCH. A redirect in the same cycle
    // suppresses it so that the stale pc_reg is never requested. Reset also
    // masks it because the memory is reset in the same cycle.
    assign w_req = (r_state == S_FETCH) && !br_taken && !reset;

    // The buffer is delivered only when the stall and the redirect are both low.
    assign w_hold_deliver = (r_state == S_HOLD) && r_buf_valid
                            && !IF_stall && !br_taken && !reset;

`ifdef FETCH_BYPASS_EN
    // A clean response with no stall is delivered in the cycle it arrives.
    assign w_bypass = (r_state == S_WAIT) && imem_rvalid && !r_discard
                      && !br_taken && !IF_stall && !reset;
`else
    assign w_bypass = 1'b0;
`endif

    // The memory request and the delivery to IF/ID are combinational.
    // IF/ID registers the delivery.
    always_comb begin
        imem_req  = w_req;
        imem_addr = r_pc_reg;
        IF_inst   = NOP_INST;
        IF_pc     = 32'h0000_0000;
        if (w_hold_deliver) begin
            IF_inst = r_buf_inst;
            IF_pc   = r_buf_pc;
        end else if (w_bypass) begin
            IF_inst = imem_rdata;
            IF_pc   = r_req_pc;
        end
    end

    // Fetch FSM with synchronous reset. Priority is reset, then redirect,
    // then stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_pc_reg    <= RESET_PC;
            r_req_pc    <= 32'h0000_0000;
            r_buf_inst  <= NOP_INST;
            r_buf_pc    <= 32'h0000_0000;
            r_buf_valid <= 1'b0;
            r_discard   <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    // rvalid is ignored here. A response to a request made
                    // before reset can arrive in this state and is dropped.
                    if (br_taken) begin
                        r_pc_reg <= br_target;
                    end else if (imem_gnt) begin
                        r_req_pc <= r_pc_reg;
                        r_pc_reg <= r_pc_reg + 32'd4;
                        r_state  <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_discard || br_taken) begin
                            r_discard <= 1'b0;
                            if (br_taken) begin
                                r_pc_reg <= br_target;
                            end
                            r_state <= S_FETCH;
                        end else if (w_bypass) begin
                            r_state <= S_FETCH;
                        end else begin
                            r_buf_inst  <= imem_rdata;
                            r_buf_pc    <= r_req_pc;
                            r_buf_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end
                    end else if (br_taken) begin
                        // The request is still outstanding. Remember to drop
                        // its response when it arrives.
                        r_pc_reg  <= br_target;
                        r_discard <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (br_taken) begin
                        r_buf_valid <= 1'b0;
                        r_pc_reg    <= br_target;
                        r_state     <= S_FETCH;
                    end else if (!IF_stall) begin
                        r_buf_valid <= 1'b0;
                        r_state     <= S_FETCH;
                    end
                end

                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch. The memory side is driven by hand, one
// cycle at a time. Inputs change 1ns after the rising edge, and the outputs
// are sampled 1ns after that.
module tb_if_fetch;

    localparam logic [0:31] NOP = 32'hF000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        IF_stall;
    logic        br_taken;
    logic [0:31] br_target;
    logic        imem_req;
    logic [0:31] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [0:31] imem_rdata;
    logic [0:31] IF_inst;
    logic [0:31] IF_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .IF_stall    (IF_stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .IF_inst     (IF_inst),
        .IF_pc       (IF_pc)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick;
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        #1;
        total++;
        if ({imem_req, IF_inst, IF_pc} !== {1'b0, NOP, 32'h0}) begin
            bad++;
            $display("FAIL reset_outputs: req=%b inst=%h pc=%h want 0/f0000000/00000000", imem_req, IF_inst, IF_pc);
        end
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        tick;
        reset = 1'b0;
        #1;
        total++;
        if ({imem_req, imem_addr, IF_inst, IF_pc} !== {1'b1, 32'h0, NOP, 32'h0}) begin
            bad++;
            $display("FAIL reset_first_req: req=%b addr=%h inst=%h pc=%h want 1/00000000/f0000000/00000000", imem_req, imem_addr, IF_inst, IF_pc);
        end
        // A stray rvalid while in FETCH must be ignored.
        imem_rvalid = 1'b1; imem_rdata = 32'h9999_9999;
        tick;
        imem_rvalid = 1'b0;
        #1;
        total++;
        if ({imem_req, imem_addr, IF_inst, IF_pc} !== {1'b1, 32'h0, NOP, 32'h0}) begin
            bad++;
            $display("FAIL fetch_ignores_rvalid: req=%b addr=%h inst=%h pc=%h want 1/00000000/f0000000/00000000", imem_req, imem_addr, IF_inst, IF_pc);
        end
    endtask

    task automatic test_basic;
        // IF_stall is held high on the response cycle so that the bypass
        // build also takes the buffered path. A stall has no effect in WAIT otherwise.
        tick;
        imem_gnt = 1'b1;
        #1;
        total++;
        if ({imem_req, imem_addr, IF_inst} !== {1'b1, 32'h0, NOP}) begin
            bad++;
            $display("FAIL basic_req0: req=%b addr=%h inst=%h want 1/00000000/f0000000", imem_req, imem_addr, IF_inst);
        end
        tick;
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111; IF_stall = 1'b1;
        #1;
        total++;
        if ({imem_req, IF_inst, IF_pc} !== {1'b0, NOP, 32'h0}) begin
            bad++;
            $display("FAIL basic_wait0: req=%b inst=%h pc=%h want 0/f0000000/00000000", imem_req, IF_inst, IF_pc);
        end
        tick;
        imem_rvalid = 1'b0; IF_stall = 1'b0;
        #1;
        total++;
        if ({imem_req, IF_inst, IF_pc} !== {1'b0, 32'h1111_1111, 32'h0}) begin
            bad++;
            $display("FAIL basic_deliver0: req=%b inst=%h pc=%h want 0/11111111/00000000", imem_req, IF_inst, IF_pc);
        end
        tick;
        #1;
        total++;
        if ({imem_req, imem_addr, IF_inst, IF_pc} !== {1'b1, 32'h4, NOP, 32'h0}) begin
            bad++;
            $display("FAIL basic_req4: req=%b addr=%h inst=%h pc=%h want 1/00000004/f0000000/00000000", imem_req, imem_addr, IF_inst, IF_pc);
        end
        imem_gnt = 1'b1;
        tick;
        imem_gnt = 1'b0;
        #1;
        total++;
        if ({imem_req, IF_inst} !== {1'b0, NOP}) begin
            bad++;
            $display("FAIL basic_wait4: req=%b inst=%h want 0/f0000000", imem_req, IF_inst);
        end
        tick;
        imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_0004; IF_stall = 1'b1;
        tick;
        imem_rvalid = 1'b0; IF_stall = 1'b0;
        #1;
        total++;
        if ({imem_req, IF_inst, IF_pc} !== {1'b0, 32'hAAAA_0004, 32'h4}) begin
            bad++;
            $display("FAIL basic_deliver4: req=%b inst=%h pc=%h want 0/aaaa0004/00000004", imem_req, IF_inst, IF_pc);
        end
    endtask

    task automatic test_stall;
        tick;
        imem_gnt = 1'b1;
        #1;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
            bad++;
            $display("FAIL stall_req8: req=%b addr=%h want 1/00000008", imem_req, imem_addr);
        end
        tick;
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222; IF_stall = 1'b1;
        tick;
        imem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick;
            #1;
            total++;
            if ({imem_req, IF_inst, IF_pc} !== {1'b0, NOP, 32'h0}) begin
                bad++;
                $display("FAIL stall_hold_cycle%0d: req=%b inst=%h pc=%h want 0/f0000000/00000000", i, imem_req, IF_inst, IF_pc);
            end
        end
        tick;
        IF_stall = 1'b0;
        #1;
        total++;
        if ({imem_req, IF_inst, IF_pc} !== {1'b0, 32'h2222_2222, 32'h8}) begin
            bad++;
            $display("FAIL stall_replay: req=%b inst=%h pc=%h want 0/22222222/00000008", imem_req, IF_inst, IF_pc);
        end
        tick;
        #1;
        total++;
        if ({imem_req, imem_addr, IF_inst, IF_pc} !== {1'b1, 32'hC, NOP, 32'h0}) begin
            bad++;
            $display("FAIL stall_once: req=%b addr=%h inst=%h pc=%h want 1/0000000c/f0000000/00000000", imem_req, imem_addr, IF_inst, IF_pc);
        end
    endtask

    task automatic test_branch_wait;
        tick;
        imem_gnt = 1'b1;
        tick;
        imem_gnt = 1'b0; br_taken = 1'b1; br_target = 32'h100;
        #1;
        total++;
        if ({imem_req, IF_inst} !== {1'b0, NOP}) begin
            bad++;
            $display("FAIL brwait_redirect: req=%b inst=%h want 0/f0000000", imem_req, IF_inst);
        end
        tick;
        br_taken = 1'b0;
        tick;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        total++;
        if ({imem_req, IF_inst, IF_pc} !== {1'b0, NOP, 32'h0}) begin
            bad++;
            $display("FAIL brwait_drop: req=%b inst=%h pc=%h want 0/f0000000/00000000", imem_req, IF_inst, IF_pc);
        end
        tick;
        imem_rvalid = 1'b0;
        #1;
        total++;
        if ({imem_req, imem_addr, IF_inst, IF_pc} !== {1'b1, 32'h100, NOP, 32'h0}) begin
            bad++;
            $display("FAIL brwait_req100: req=%b addr=%h inst=%h pc=%h want 1/00000100/f0000000/00000000", imem_req, imem_addr, IF_inst, IF_pc);
        end
        imem_gnt = 1'b1;
        tick;
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555; IF_stall = 1'b1;
        tick;
        imem_rvalid = 1'b0; IF_stall = 1'b0;
        #1;
        total++;
        if ({IF_inst, IF_pc} !== {32'h5555_5555, 32'h100}) begin
            bad++;
            $display("FAIL brwait_deliver100: inst=%h pc=%h want 55555555/00000100", IF_inst, IF_pc);
        end
        tick;
        #1;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h104}) begin
            bad++;
            $display("FAIL brwait_req104: req=%b addr=%h want 1/00000104", imem_req, imem_addr);
        end
    endtask

    task automatic test_branch_stall_hold;
        imem_gnt = 1'b1;
        tick;
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h6666_6666; IF_stall = 1'b1;
        tick;
        imem_rvalid = 1'b0; br_taken = 1'b1; br_target = 32'h200;
        #1;
        total++;
        if ({imem_req, IF_inst, IF_pc} !== {1'b0, NOP, 32'h0}) begin
            bad++;
            $display("FAIL brhold_nop: req=%b inst=%h pc=%h want 0/f0000000/00000000", imem_req, IF_inst, IF_pc);
        end
        tick;
        br_taken = 1'b0; IF_stall = 1'b0;
        #1;
        total++;
        if ({imem_req, imem_addr, IF_inst, IF_pc} !== {1'b1, 32'h200, NOP, 32'h0}) begin
            bad++;
            $display("FAIL brhold_req200: req=%b addr=%h inst=%h pc=%h want 1/00000200/f0000000/00000000", imem_req, imem_addr, IF_inst, IF_pc);
        end
    endtask

    task automatic test_gnt_withheld;
        for (int i = 0; i < 5; i++) begin
            tick;
            #1;
            total++;
            if ({imem_req, imem_addr, IF_inst, IF_pc} !== {1'b1, 32'h200, NOP, 32'h0}) begin
                bad++;
                $display("FAIL nognt_cycle%0d: req=%b addr=%h inst=%h pc=%h want 1/00000200/f0000000/00000000", i, imem_req, imem_addr, IF_inst, IF_pc);
            end
        end
        imem_gnt = 1'b1;
        tick;
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h7777_7777; IF_stall = 1'b1;
        tick;
        imem_rvalid = 1'b0; IF_stall = 1'b0;
        #1;
        total++;
        if ({IF_inst, IF_pc} !== {32'h7777_7777, 32'h200}) begin
            bad++;
            $display("FAIL nognt_deliver: inst=%h pc=%h want 77777777/00000200", IF_inst, IF_pc);
        end
        tick;
        #1;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h204}) begin
            bad++;
            $display("FAIL nognt_req204: req=%b addr=%h want 1/00000204", imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap;
        br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
        #1;
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("FAIL wrap_req_masked: req=%b want 0", imem_req);
        end
        tick;
        br_taken = 1'b0;
        #1;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            bad++;
            $display("FAIL wrap_req_top: req=%b addr=%h want 1/fffffffc", imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        tick;
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h8888_8888; IF_stall = 1'b1;
        tick;
        imem_rvalid = 1'b0; IF_stall = 1'b0;
        #1;
        total++;
        if ({IF_inst, IF_pc} !== {32'h8888_8888, 32'hFFFF_FFFC}) begin
            bad++;
            $display("FAIL wrap_deliver: inst=%h pc=%h want 88888888/fffffffc", IF_inst, IF_pc);
        end
        tick;
        #1;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            bad++;
            $display("FAIL wrap_req_zero: req=%b addr=%h want 1/00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_back_to_back;
        imem_gnt = 1'b1;
        tick;
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333; IF_stall = 1'b0;
        #1;
`ifdef FETCH_BYPASS_EN
        total++;
        if ({imem_req, IF_inst, IF_pc} !== {1'b0, 32'h3333_3333, 32'h0}) begin
            bad++;
            $display("FAIL b2b_bypass: req=%b inst=%h pc=%h want 0/33333333/00000000", imem_req, IF_inst, IF_pc);
        end
        tick;
        imem_rvalid = 1'b0;
`else
        total++;
        if ({imem_req, IF_inst, IF_pc} !== {1'b0, NOP, 32'h0}) begin
            bad++;
            $display("FAIL b2b_rvalid_nop: req=%b inst=%h pc=%h want 0/f0000000/00000000", imem_req, IF_inst, IF_pc);
        end
        tick;
        imem_rvalid = 1'b0;
        #1;
        total++;
        if ({imem_req, IF_inst, IF_pc} !== {1'b0, 32'h3333_3333, 32'h0}) begin
            bad++;
            $display("FAIL b2b_deliver: req=%b inst=%h pc=%h want 0/33333333/00000000", imem_req, IF_inst, IF_pc);
        end
        tick;
`endif
        #1;
        total++;
        if ({imem_req, imem_addr, IF_inst} !== {1'b1, 32'h4, NOP}) begin
            bad++;
            $display("FAIL b2b_next_req: req=%b addr=%h inst=%h want 1/00000004/f0000000", imem_req, imem_addr, IF_inst);
        end
    endtask

    task automatic test_reset_midflight;
        imem_gnt = 1'b1;
        tick;
        imem_gnt = 1'b0; reset = 1'b1;
        #1;
        total++;
        if ({imem_req, IF_inst, IF_pc} !== {1'b0, NOP, 32'h0}) begin
            bad++;
            $display("FAIL midreset_outputs: req=%b inst=%h pc=%h want 0/f0000000/00000000", imem_req, IF_inst, IF_pc);
        end
        tick;
        reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBADB_AD00;
        #1;
        total++;
        if ({imem_req, imem_addr, IF_inst, IF_pc} !== {1'b1, 32'h0, NOP, 32'h0}) begin
            bad++;
            $display("FAIL midreset_restart: req=%b addr=%h inst=%h pc=%h want 1/00000000/f0000000/00000000", imem_req, imem_addr, IF_inst, IF_pc);
        end
        tick;
        imem_rvalid = 1'b0;
        #1;
        total++;
        if ({imem_req, imem_addr, IF_inst, IF_pc} !== {1'b1, 32'h0, NOP, 32'h0}) begin
            bad++;
            $display("FAIL midreset_stale_dropped: req=%b addr=%h inst=%h pc=%h want 1/00000000/f0000000/00000000", imem_req, imem_addr, IF_inst, IF_pc);
        end
    endtask

    initial begin
        reset       = 1'b1;
        IF_stall    = 1'b0;
        br_taken    = 1'b0;
        br_target   = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        test_reset;
        test_basic;
        test_stall;
        test_branch_wait;
        test_branch_stall_hold;
        test_gnt_withheld;
        test_wrap;
        test_back_to_back;
        test_reset_midflight;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the CPU pipeline, sitting directly upstream of the IF/ID pipeline register. Holds the program counter, issues one instruction-memory read at a time over a req/gnt/rvalid handshake, and presents each fetched instruction and its PC on `IF_inst`/`IF_pc` for exactly one cycle. The IF/ID register latches every cycle, so this block presents the NOP word `32'hF0000000` with PC 0 whenever no instruction is delivered. It also handles pipeline stalls (bubble and replay) and branch redirects (discard in-flight work).

## Interface
- `RESET_PC`, default `32'h00000000`: first fetch address after reset.
- `NOP_INST`, default `32'hF0000000`: word presented when no instruction is delivered.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `IF_stall` input 1: stall. Do not deliver this cycle; present NOP and keep any buffered instruction for replay.
- `br_taken` input 1: redirect fetch to `br_target`.
- `br_target` input [0:31]: redirect address; bit 0 is MSB.
- `imem_req` output 1: read request.
- `imem_addr` output [0:31]: read address, valid while `imem_req`=1.
- `imem_gnt` input 1: memory accepts the request this cycle.
- `imem_rvalid` input 1: read data valid.
- `imem_rdata` input [0:31]: read data.
- `IF_inst` output [0:31]: instruction to IF/ID.
- `IF_pc` output [0:31]: PC of `IF_inst`. It is 0 whenever `IF_inst` is NOP_INST.

## Operation
- Registers:
  - `pc_reg`: next fetch address.
  - `req_pc`: PC of the outstanding request.
  - `buf_inst`/`buf_pc`/`buf_valid`: one-entry hold buffer.
  - `discard`: flag that drops the pending response.
  - FSM with states FETCH, WAIT, HOLD.
- At most one memory request is outstanding at any time.
- FETCH:
  - `imem_req` = !`br_taken`; `imem_addr` = `pc_reg`.
  - Request accepted (`imem_req` && `imem_gnt`): `req_pc`<=`pc_reg`, `pc_reg`<=`pc_reg`+4 (mod 2^32, wraps silently), go to WAIT.
  - `br_taken`: `pc_reg`<=`br_target`, stay in FETCH.
  - `imem_rvalid` is ignored in this state.
- WAIT (`imem_req`=0):
  - `br_taken` without `imem_rvalid`: `pc_reg`<=`br_target`, `discard`<=1, stay in WAIT.
  - `imem_rvalid` with `discard` or `br_taken`: drop the data, clear `discard`, go to FETCH. If `br_taken` is high, `pc_reg`<=`br_target`.
  - `imem_rvalid` otherwise: `buf_inst`<=`imem_rdata`, `buf_pc`<=`req_pc`, `buf_valid`<=1, go to HOLD. See Configuration for the bypass variant.
- HOLD (`imem_req`=0):
  - Deliver when !`IF_stall` && !`br_taken`: `IF_inst`=`buf_inst`, `IF_pc`=`buf_pc`, clear `buf_valid`, go to FETCH.
  - `IF_stall` (without `br_taken`): present NOP, stay in HOLD.
  - `br_taken`: present NOP, clear `buf_valid`, `pc_reg`<=`br_target`, go to FETCH.
- Priority: `reset` > `br_taken` > `IF_stall`.
- Outside a delivery cycle, `IF_inst`=NOP_INST and `IF_pc`=0.

## Timing
- Reset values: state FETCH, `pc_reg`=RESET_PC, `buf_valid`=0, `discard`=0.
- Outputs during the reset cycle: `imem_req`=0, `IF_inst`=NOP_INST, `IF_pc`=0.
- A response arriving after reset for a request issued before reset is ignored, because the FSM is in FETCH and does not sample `imem_rvalid` there. The memory shares `reset`.
- `imem_req`/`imem_addr` hold stable in FETCH until `imem_gnt`, unless a redirect occurs.
- `IF_inst`/`IF_pc` are combinational from state, buffer and inputs. IF/ID registers them.
- Latency without bypass: gnt in cycle N, rvalid in N+1, delivery in N+2 at the earliest, next request in N+3.
- Peak throughput: 1 instruction per 3 cycles (per 2 with bypass).
- Every accepted, non-discarded response is delivered exactly once. No instruction is duplicated or skipped except by redirect.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - In WAIT, on `imem_rvalid` && !`discard` && !`br_taken` && !`IF_stall`, present `imem_rdata`/`req_pc` on `IF_inst`/`IF_pc` in the same cycle and go straight to FETCH; the buffer is not written.
  - If `IF_stall` is high on that cycle, the response goes to HOLD as normal.
- `FETCH_BYPASS_EN` undefined: every response passes through HOLD.

## Test plan
- Reset, `imem_gnt`=1, rvalid one cycle after gnt with data 0x11111111 → first `imem_addr`=0x00000000. `IF_inst`=0x11111111, `IF_pc`=0 two cycles after gnt. Next `imem_addr`=0x00000004.
- Stall 3 cycles while in HOLD holding 0x22222222 at PC 0x8 → NOP/PC 0 for 3 cycles, then 0x22222222/0x8 exactly once.
- `br_taken` with target 0x100 during WAIT, rvalid 2 cycles later → response never appears on `IF_inst`. Next `imem_addr`=0x100, and the following one is 0x104.
- `br_taken` (target 0x200) and `IF_stall` in the same HOLD cycle → buffer dropped, NOP output, next `imem_addr`=0x200.
- `imem_gnt` withheld 5 cycles → `imem_req`=1 and `imem_addr` stable for all 5 cycles, `IF_inst`=NOP throughout.
- `pc_reg`=0xFFFFFFFC fetch → next `imem_addr`=0x00000000.
- `FETCH_BYPASS_EN` build, rvalid with 0x33333333 and no stall → `IF_inst`=0x33333333 in the rvalid cycle, `imem_req`=1 in the next cycle.
